// File: rtl/mult_pkg.sv
// Shared state codes and shift-amount helper for the sequential multiplier core.
package mult_pkg;

   localparam int STATE_W = 3;

   // The state code is also the progress digit that the seven-segment display shows.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 3'd0,
      ST_LL   = 3'd1,
      ST_HL   = 3'd2,
      ST_LH   = 3'd3,
      ST_HH   = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   // Weight of the partial product formed in each state: 0, H or 2H.
   function automatic int unsigned shift_for(input state_t st, input int unsigned h);
      case (st)
         ST_HL, ST_LH: return h;
         ST_HH:        return 2 * h;
         default:      return 0;
      endcase
   endfunction

endpackage

// File: rtl/mult8x8_seq_core_mult4x4.sv
// Combinational HxH -> 2H unsigned multiplier; the only multiplier in the core.
module mult4x4 #(
   parameter int H = 4
) (
   input  logic [H-1:0]   a,
   input  logic [H-1:0]   b,
   output logic [2*H-1:0] p
);

   assign p = a * b;

endmodule

// File: rtl/mult8x8_seq_core.sv
// Sequential unsigned multiplier: one half-by-half partial product per cycle, shift-added
// into the accumulator. Define MULT_ERR_EN to add a sticky error flag for starts while busy.
module mult8x8_seq_core
   import mult_pkg::*;
#(
   parameter int OPERAND_W = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [OPERAND_W-1:0]   dataa,
   input  logic [OPERAND_W-1:0]   datab,
   output logic [2*OPERAND_W-1:0] product,
   output logic                   done_flag,
   output logic [STATE_W-1:0]     state_out,
   output logic                   err
);

   localparam int unsigned H  = OPERAND_W / 2;
   localparam int          PW = 2 * OPERAND_W;

   state_t               state;
   logic [OPERAND_W-1:0] a_reg;
   logic [OPERAND_W-1:0] b_reg;
   logic [H-1:0]         mul_a;
   logic [H-1:0]         mul_b;
   logic [2*H-1:0]       pp;
   logic [PW-1:0]        pp_shift;

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      mul_a = a_reg[H-1:0];
      mul_b = b_reg[H-1:0];
      case (state)
         ST_HL: mul_a = a_reg[OPERAND_W-1:H];
         ST_LH: mul_b = b_reg[OPERAND_W-1:H];
         ST_HH: begin
            mul_a = a_reg[OPERAND_W-1:H];
            mul_b = b_reg[OPERAND_W-1:H];
         end
         default: ;
      endcase
   end

   mult4x4 #(.H(H)) u_mult4x4 (
      .a (mul_a),
      .b (mul_b),
      .p (pp)
   );

   assign pp_shift = PW'(pp) << shift_for(state, H);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         product   <= '0;
         done_flag <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  a_reg     <= dataa;
                  b_reg     <= datab;
                  product   <= '0;
                  done_flag <= 1'b0;
                  state     <= ST_LL;
               end
            end
            ST_LL: begin
               product <= product + pp_shift;
               state   <= ST_HL;
            end
            ST_HL: begin
               product <= product + pp_shift;
               state   <= ST_LH;
            end
            ST_LH: begin
               product <= product + pp_shift;
               state   <= ST_HH;
            end
            ST_HH: begin
               product   <= product + pp_shift;
               done_flag <= 1'b1;
               state     <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign state_out = state;

`ifdef MULT_ERR_EN
   logic err_q;

   // Sticky until the next accepted start; never disturbs the running multiply.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else if (start) begin
         if (state == ST_IDLE || state == ST_DONE)
            err_q <= 1'b0;
         else if (state inside {ST_LL, ST_HL, ST_LH, ST_HH})
            err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mult8x8_seq_core.sv
// Self-checking bench for mult8x8_seq_core: directed scenarios plus randomized multiplies
// compared against an arithmetic reference of the partial-product sums.
module tb_mult8x8_seq_core;

   localparam int W = 8;

`ifdef MULT_ERR_EN
   localparam bit ERR_ON = 1'b1;
`else
   localparam bit ERR_ON = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset_n;
   logic           start;
   logic [W-1:0]   dataa;
   logic [W-1:0]   datab;
   logic [2*W-1:0] product;
   logic           done_flag;
   logic [2:0]     state_out;
   logic           err;

   int n_checks = 0;
   int n_pass   = 0;

   mult8x8_seq_core #(.OPERAND_W(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .dataa     (dataa),
      .datab     (datab),
      .product   (product),
      .done_flag (done_flag),
      .state_out (state_out),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Running sum after the first 'steps' partial products, in the order lo*lo, hi*lo, lo*hi, hi*hi.
   function automatic logic [31:0] partial(input logic [7:0] a, input logic [7:0] b, input int steps);
      int unsigned al = a % 16, ah = a / 16, bl = b % 16, bh = b / 16;
      int unsigned s = 0;
      if (steps >= 1) s += al * bl;
      if (steps >= 2) s += ah * bl * 16;
      if (steps >= 3) s += al * bh * 16;
      if (steps >= 4) s += ah * bh * 256;
      return s;
   endfunction

   // Full multiply from IDLE or DONE; optionally pokes start (with junk data) while in HL.
   task automatic mult_op(input logic [7:0] a, input logic [7:0] b, input bit poke);
      for (int i = 1; i <= 5; i++) begin
         if (i == 1) begin
            dataa = a;
            datab = b;
            start = 1'b1;
         end else begin
            start = poke && (i == 3);
            if (start) dataa = 8'h00;
         end
         tick();
         start = 1'b0;
         check($sformatf("state_e%0d", i), state_out, i);
         check($sformatf("prod_e%0d", i), product, partial(a, b, i - 1));
         check($sformatf("done_e%0d", i), done_flag, (i == 5));
         if (i == 1) check("err_cleared", err, 0);
         dataa = 8'($urandom);
         datab = 8'($urandom);
      end
      check("final_prod", product, 32'(a) * 32'(b));
      check("err_after", err, ERR_ON && poke);
   endtask

   initial begin
      // 1: reset held with start high
      reset_n = 1'b0;
      start   = 1'b1;
      dataa   = 8'hA5;
      datab   = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_prod", product, 0);
         check("rst_done", done_flag, 0);
         check("rst_state", state_out, 0);
         check("rst_err", err, 0);
      end
      start   = 1'b0;
      reset_n = 1'b1;
      tick();
      check("idle_hold", state_out, 0);

      // 2 and 3: maximum operands, then a typical pair with a long hold in DONE
      mult_op(8'hFF, 8'hFF, 1'b0);
      check("ff_ff", product, 16'hFE01);
      mult_op(8'h12, 8'h34, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("hold_prod", product, 16'h03A8);
         check("hold_done", done_flag, 1);
         check("hold_state", state_out, 5);
      end

      // 4: start while busy is ignored
      mult_op(8'h5A, 8'hC3, 1'b1);

      // 5: reset in the middle of the sequence
      dataa = 8'hF0;
      datab = 8'h0F;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("mid_state_lh", state_out, 3);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_prod", product, 0);
      check("midrst_state", state_out, 0);
      check("midrst_done", done_flag, 0);
      tick();
      reset_n = 1'b1;
      tick();
      mult_op(8'h03, 8'h05, 1'b0);
      check("three_five", product, 16'h000F);

      // 6: back-to-back restarts from DONE, including a zero operand
      mult_op(8'h0A, 8'h0B, 1'b0);
      check("a_b", product, 16'h006E);
      mult_op(8'h00, 8'($urandom), 1'b0);
      check("zero_a", product, 0);

      // Randomized multiplies with idle gaps and busy pokes
      for (int n = 0; n < 40; n++) begin
         logic [7:0] ra, rb;
         logic [15:0] exp_p;
         int gap;
         ra    = 8'($urandom);
         rb    = 8'($urandom);
         exp_p = 16'(32'(ra) * 32'(rb));
         mult_op(ra, rb, 1'($urandom));
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            tick();
            check("rnd_hold", product, exp_p);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
